// File: rtl/program_loader.sv
// Byte-stream boot loader: parses a framed, XOR-checksummed program image,
// writes big-endian words into program memory and releases the CPU once the
// checksum matches. Any oversize frame or bad checksum parks it in ERROR.
module program_loader #(
    parameter int MEM_WORDS      = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] pmemaddr,
    output logic [31:0] pmemdata,
    output logic        pmemwe,
    output logic        cpustate,
    output logic        error,
    output logic [15:0] words_loaded
);

    // The idle counter only needs to reach TIMEOUT_CYCLES-1: the abort fires
    // on the idle cycle that would make it TIMEOUT_CYCLES.
    localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   MAXW   = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [1:0]    byte_cnt;
    logic [15:0]   word_idx;
    logic [15:0]   nwords;
    logic [7:0]    acc;
    logic [TW-1:0] tcnt;
    logic [31:0]   shift_p0;

    logic [31:0]   wr_addr_p1;
    logic [31:0]   wr_data_p1;
    logic          vld_p1;
    logic [15:0]   wl_p1;

    logic          accept;
    logic          in_frame;
    logic          timeout;
    logic          last_byte;
    logic          last_word;
    logic [31:0]   full_word;

    // Byte acceptance, idle-timeout detection and the word being completed.
    always_comb begin
        accept    = 1'b0;
        in_frame  = 1'b0;
        timeout   = 1'b0;
        last_byte = (byte_cnt == 2'd3);
        last_word = (word_idx == (nwords - 16'd1));
        full_word = {shift_p0[23:0], rx_data};
        case (state)
            S_LEN: begin
                accept   = rx_valid;
                in_frame = (byte_cnt != 2'd0);
            end
            S_LOAD, S_CHECK: begin
                accept   = rx_valid;
                in_frame = 1'b1;
            end
            default: begin
                accept   = 1'b0;
                in_frame = 1'b0;
            end
        endcase
        timeout = in_frame && !rx_valid && (tcnt == TLAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: count, payload, checksum, then a terminal state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN: begin
                if (accept && last_byte) begin
                    if (full_word > MAXW) begin
                        state_nxt = S_ERROR;
                    end else if (full_word == 32'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (timeout) begin
                    state_nxt = S_LEN;
                end else if (accept && last_byte && last_word) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (timeout) begin
                    state_nxt = S_LEN;
                end else if (accept) begin
                    state_nxt = (rx_data == acc) ? S_RUN : S_ERROR;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // Byte assembly, checksum accumulation and idle timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            word_idx <= 16'd0;
            nwords   <= 16'd0;
            acc      <= 8'd0;
            tcnt     <= '0;
        end else if (timeout) begin
            byte_cnt <= 2'd0;
            word_idx <= 16'd0;
            acc      <= 8'd0;
            tcnt     <= '0;
        end else if (accept) begin
            tcnt     <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state != S_CHECK) begin
                acc <= acc ^ rx_data;
            end
            if (state == S_LEN && last_byte) begin
                nwords <= full_word[15:0];
            end
            if (state == S_LOAD && last_byte) begin
                word_idx <= word_idx + 16'd1;
            end
        end else if (in_frame) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Shift register holding the count bytes or the word under assembly.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_p0 <= full_word;
        end
    end

    // ---- p0 -> p1: completed word becomes a one-cycle memory write ----
    // Write port: pulse on completion, address/data held until the next write.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= 32'd0;
            wr_data_p1 <= 32'd0;
            wl_p1      <= 16'd0;
        end else begin
            vld_p1 <= 1'b0;
            if (timeout) begin
                wl_p1 <= 16'd0;
            end else if (accept && state == S_LOAD && last_byte) begin
                vld_p1     <= 1'b1;
                wr_addr_p1 <= {14'd0, word_idx, 2'b00};
                wr_data_p1 <= full_word;
                wl_p1      <= word_idx + 16'd1;
            end
        end
    end

    // Status and write-port outputs come straight from registers.
    always_comb begin
        pmemwe       = vld_p1;
        pmemaddr     = wr_addr_p1;
        pmemdata     = wr_data_p1;
        words_loaded = wl_p1;
        cpustate     = (state == S_RUN);
        error        = (state == S_ERROR);
    end

endmodule
